// File: rtl/spi_regbank_if.sv
// Bus bundle between the SPI slave / processor side and the shared register bank.
// The slave modport is the register bank's view; master is the driving side.
interface spi_regbank_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic              spi_we;
    logic [ADDR_W-1:0] spi_addr;
    logic [DATA_W-1:0] spi_wdata;
    logic [DATA_W-1:0] spi_rdata;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_data;
    logic              upd_pulse;
    logic [ADDR_W-1:0] upd_addr;

    modport slave (
        input  spi_we, spi_addr, spi_wdata, cpu_we, cpu_addr, cpu_wdata, cmd_ready,
        output spi_rdata, cpu_rdata, cmd_valid, cmd_data, upd_pulse, upd_addr
    );

    modport master (
        output spi_we, spi_addr, spi_wdata, cpu_we, cpu_addr, cpu_wdata, cmd_ready,
        input  spi_rdata, cpu_rdata, cmd_valid, cmd_data, upd_pulse, upd_addr
    );
endinterface

// File: rtl/spi_regbank.sv
// Dual-ported register bank: SPI and processor share general words, plus a status
// word and a doorbell mailbox that hands SPI commands to the processor.
module spi_regbank #(
    parameter int ADDR_W        = 7,
    parameter int DATA_W        = 32,
    parameter int STATUS_ADDR   = 126,
    parameter int DOORBELL_ADDR = 127
) (
    input  logic          clk,
    input  logic          reset,
    spi_regbank_if.slave  bus
);
    localparam int                NUM_WORDS  = STATUS_ADDR;
    localparam logic [ADDR_W-1:0] STATUS_A   = ADDR_W'(STATUS_ADDR);
    localparam logic [ADDR_W-1:0] DOORBELL_A = ADDR_W'(DOORBELL_ADDR);

    typedef enum logic {MB_EMPTY, MB_FULL} mb_state_t;

    mb_state_t         mb_state_reg, mb_state_next;
    logic [DATA_W-1:0] mem_reg [NUM_WORDS];
    logic [DATA_W-1:0] cmd_data_reg, cmd_data_next;
    logic              overflow_reg, overflow_next;
    logic [7:0]        count_reg, count_next;
    logic [DATA_W-1:0] cpu_rdata_reg;
    logic              upd_pulse_reg;
    logic [ADDR_W-1:0] upd_addr_reg;
    logic [NUM_WORDS-1:0] spi_hit, cpu_hit;
    logic [DATA_W-1:0] status_word;
    logic              cmd_valid, drain, db_write, db_accept, db_drop, ovf_clear, spi_general;

    generate
        for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_hit
            assign spi_hit[gi] = bus.spi_we && (bus.spi_addr == ADDR_W'(gi));
            assign cpu_hit[gi] = bus.cpu_we && (bus.cpu_addr == ADDR_W'(gi));
        end
    endgenerate

    // SPI has priority over the processor on a same-word collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_WORDS; i++) mem_reg[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                if (spi_hit[i])      mem_reg[i] <= bus.spi_wdata;
                else if (cpu_hit[i]) mem_reg[i] <= bus.cpu_wdata;
            end
        end
    end

    always_comb begin
        status_word       = '0;
        status_word[0]    = cmd_valid;
        status_word[1]    = overflow_reg;
        status_word[15:8] = count_reg;
    end

    function automatic logic [DATA_W-1:0] read_word(input logic [ADDR_W-1:0] addr);
        if (addr == STATUS_A)        return status_word;
        else if (addr == DOORBELL_A) return cmd_data_reg;
        else                         return mem_reg[addr];
    endfunction

    assign cmd_valid   = (mb_state_reg == MB_FULL);
    assign drain       = cmd_valid && bus.cmd_ready;
    assign db_write    = bus.spi_we && (bus.spi_addr == DOORBELL_A);
    assign db_accept   = db_write && (!cmd_valid || bus.cmd_ready);
    assign db_drop     = db_write && !db_accept;
    assign ovf_clear   = bus.spi_we && (bus.spi_addr == STATUS_A) && bus.spi_wdata[1];
    assign spi_general = bus.spi_we && (bus.spi_addr < STATUS_A);

    always_ff @(posedge clk) begin
        if (reset) begin
            mb_state_reg  <= MB_EMPTY;
            cmd_data_reg  <= '0;
            overflow_reg  <= 1'b0;
            count_reg     <= '0;
            cpu_rdata_reg <= '0;
            upd_pulse_reg <= 1'b0;
            upd_addr_reg  <= '0;
        end else begin
            mb_state_reg  <= mb_state_next;
            cmd_data_reg  <= cmd_data_next;
            overflow_reg  <= overflow_next;
            count_reg     <= count_next;
            cpu_rdata_reg <= read_word(bus.cpu_addr);
            upd_pulse_reg <= spi_general;
            if (spi_general) upd_addr_reg <= bus.spi_addr;
        end
    end

    // A doorbell accepted in the draining cycle keeps the mailbox full.
    always_comb begin
        mb_state_next = mb_state_reg;
        cmd_data_next = cmd_data_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg;
        case (mb_state_reg)
            MB_EMPTY: if (db_accept) mb_state_next = MB_FULL;
            MB_FULL:  if (drain && !db_accept) mb_state_next = MB_EMPTY;
            default:  mb_state_next = MB_EMPTY;
        endcase
        if (db_accept) begin
            cmd_data_next = bus.spi_wdata;
            count_next    = count_reg + 8'd1;
        end
        if (db_drop)        overflow_next = 1'b1;
        else if (ovf_clear) overflow_next = 1'b0;
    end

    assign bus.spi_rdata = read_word(bus.spi_addr);
    assign bus.cpu_rdata = cpu_rdata_reg;
    assign bus.cmd_valid = cmd_valid;
    assign bus.cmd_data  = cmd_data_reg;
    assign bus.upd_pulse = upd_pulse_reg;
    assign bus.upd_addr  = upd_addr_reg;
endmodule

// File: tb/tb_spi_regbank.sv
// Scenario bench for spi_regbank: expected words are queued when stimulus is
// driven and popped when the corresponding DUT output is sampled.
module tb_spi_regbank;
    logic clk = 1'b0;
    logic reset;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    logic [31:0] exp_q[$];

    spi_regbank_if #(.ADDR_W(7), .DATA_W(32)) bus ();

    spi_regbank dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic spi_write(input logic [6:0] addr, input logic [31:0] data);
        bus.spi_we = 1'b1; bus.spi_addr = addr; bus.spi_wdata = data;
        $display("[%0t] spi write addr=%0d data=%h", $time, addr, data);
        tick();
        bus.spi_we = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] exp;
        bus.spi_we = 0; bus.spi_addr = 0; bus.spi_wdata = 0;
        bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0; bus.cmd_ready = 0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        bus.spi_addr = 7'd5; #1;
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); total_cnt++;
        if (bus.spi_rdata !== exp) $display("FAIL reset_spi_rd5: got %h want %h", bus.spi_rdata, exp); else pass_cnt++;
        bus.spi_addr = 7'd126; #1;
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); total_cnt++;
        if (bus.spi_rdata !== exp) $display("FAIL reset_status: got %h want %h", bus.spi_rdata, exp); else pass_cnt++;
        bus.cpu_addr = 7'd5;
        exp_q.push_back(32'h0);
        tick();
        exp = exp_q.pop_front(); total_cnt++;
        if (bus.cpu_rdata !== exp) $display("FAIL reset_cpu_rd5: got %h want %h", bus.cpu_rdata, exp); else pass_cnt++;
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); total_cnt++;
        if ({31'b0, bus.cmd_valid} !== exp) $display("FAIL reset_cmd_valid: got %0b want %0d", bus.cmd_valid, exp); else pass_cnt++;
        $display("[%0t] reset scenario done", $time);
    endtask

    task automatic test_spi_write();
        logic [31:0] exp;
        bus.spi_addr = 7'd5;
        bus.spi_we = 1'b1; bus.spi_wdata = 32'hDEADBEEF; #1;
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); total_cnt++;
        if (bus.spi_rdata !== exp) $display("FAIL spi_pre_write: got %h want %h", bus.spi_rdata, exp); else pass_cnt++;
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'd5);
        spi_write(7'd5, 32'hDEADBEEF);
        exp = exp_q.pop_front(); total_cnt++;
        if (bus.spi_rdata !== exp) $display("FAIL spi_post_write: got %h want %h", bus.spi_rdata, exp); else pass_cnt++;
        exp = exp_q.pop_front(); total_cnt++;
        if (bus.upd_pulse !== 1'b1 || {25'b0, bus.upd_addr} !== exp)
            $display("FAIL upd_pulse: got pulse=%0b addr=%0d want pulse=1 addr=%0d", bus.upd_pulse, bus.upd_addr, exp);
        else pass_cnt++;
        bus.cpu_addr = 7'd5;
        exp_q.push_back(32'hDEADBEEF);
        tick();
        total_cnt++;
        if (bus.upd_pulse !== 1'b0) $display("FAIL upd_pulse_width: got %0b want 0", bus.upd_pulse); else pass_cnt++;
        exp = exp_q.pop_front(); total_cnt++;
        if (bus.cpu_rdata !== exp) $display("FAIL cpu_rd5: got %h want %h", bus.cpu_rdata, exp); else pass_cnt++;
    endtask

    task automatic test_cpu_port();
        logic [31:0] exp;
        bus.cpu_we = 1'b1; bus.cpu_addr = 7'd20; bus.cpu_wdata = 32'h12345678;
        $display("[%0t] cpu write addr=20 data=12345678", $time);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h12345678);
        tick();
        bus.cpu_we = 1'b0;
        exp = exp_q.pop_front(); total_cnt++;
        if (bus.cpu_rdata !== exp) $display("FAIL cpu_read_before_write: got %h want %h", bus.cpu_rdata, exp); else pass_cnt++;
        total_cnt++;
        if (bus.upd_pulse !== 1'b0) $display("FAIL cpu_no_upd: got %0b want 0", bus.upd_pulse); else pass_cnt++;
        tick();
        exp = exp_q.pop_front(); total_cnt++;
        if (bus.cpu_rdata !== exp) $display("FAIL cpu_write20: got %h want %h", bus.cpu_rdata, exp); else pass_cnt++;
        bus.cpu_we = 1'b1; bus.cpu_addr = 7'd126; bus.cpu_wdata = 32'hFFFFFFFF;
        tick();
        bus.cpu_addr = 7'd127;
        tick();
        bus.cpu_we = 1'b0;
        $display("[%0t] cpu writes to 126/127 issued", $time);
        bus.spi_addr = 7'd126; #1;
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); total_cnt++;
        if (bus.spi_rdata !== exp) $display("FAIL cpu_status_ignored: got %h want %h", bus.spi_rdata, exp); else pass_cnt++;
        bus.spi_addr = 7'd127; #1;
        exp_q.push_back(32'h0);
        exp = exp_q.pop_front(); total_cnt++;
        if (bus.spi_rdata !== exp || bus.cmd_valid !== 1'b0)
            $display("FAIL cpu_doorbell_ignored: got data=%h valid=%0b want data=%h valid=0", bus.spi_rdata, bus.cmd_valid, exp);
        else pass_cnt++;
    endtask

    task automatic test_collision();
        logic [31:0] exp;
        bus.cpu_we = 1'b1; bus.cpu_addr = 7'd10; bus.cpu_wdata = 32'h22222222;
        exp_q.push_back(32'h11111111);
        exp_q.push_back(32'd10);
        spi_write(7'd10, 32'h11111111);
        bus.cpu_we = 1'b0;
        exp = exp_q.pop_front(); total_cnt++;
        if (bus.spi_rdata !== exp) $display("FAIL collision_spi_wins: got %h want %h", bus.spi_rdata, exp); else pass_cnt++;
        exp = exp_q.pop_front(); total_cnt++;
        if (bus.upd_pulse !== 1'b1 || {25'b0, bus.upd_addr} !== exp)
            $display("FAIL collision_upd: got pulse=%0b addr=%0d want pulse=1 addr=%0d", bus.upd_pulse, bus.upd_addr, exp);
        else pass_cnt++;
        exp_q.push_back(32'h11111111);
        tick();
        exp = exp_q.pop_front(); total_cnt++;
        if (bus.cpu_rdata !== exp) $display("FAIL collision_cpu_rd: got %h want %h", bus.cpu_rdata, exp); else pass_cnt++;
    endtask

    task automatic test_doorbell();
        logic [31:0] exp;
        bus.cmd_ready = 1'b0;
        exp_q.push_back(32'h000000A5);
        exp_q.push_back(32'h00000101);
        spi_write(7'd127, 32'h000000A5);
        bus.spi_addr = 7'd126; #1;
        exp = exp_q.pop_front(); total_cnt++;
        if (bus.cmd_valid !== 1'b1 || bus.cmd_data !== exp)
            $display("FAIL db_first: got valid=%0b data=%h want valid=1 data=%h", bus.cmd_valid, bus.cmd_data, exp);
        else pass_cnt++;
        exp = exp_q.pop_front(); total_cnt++;
        if (bus.spi_rdata !== exp) $display("FAIL db_status1: got %h want %h", bus.spi_rdata, exp); else pass_cnt++;
        exp_q.push_back(32'h000000A5);
        exp_q.push_back(32'h00000103);
        spi_write(7'd127, 32'h0000005A);
        bus.spi_addr = 7'd126; #1;
        exp = exp_q.pop_front(); total_cnt++;
        if (bus.cmd_data !== exp) $display("FAIL db_busy_data: got %h want %h", bus.cmd_data, exp); else pass_cnt++;
        exp = exp_q.pop_front(); total_cnt++;
        if (bus.spi_rdata !== exp) $display("FAIL db_overflow_status: got %h want %h", bus.spi_rdata, exp); else pass_cnt++;
        bus.cmd_ready = 1'b1;
        $display("[%0t] cmd_ready pulse", $time);
        exp_q.push_back(32'h00000102);
        tick();
        bus.cmd_ready = 1'b0; #1;
        exp = exp_q.pop_front(); total_cnt++;
        if (bus.spi_rdata !== exp || bus.cmd_valid !== 1'b0)
            $display("FAIL db_drain: got status=%h valid=%0b want status=%h valid=0", bus.spi_rdata, bus.cmd_valid, exp);
        else pass_cnt++;
        exp_q.push_back(32'h00000100);
        spi_write(7'd126, 32'h00000002);
        bus.spi_addr = 7'd126; #1;
        exp = exp_q.pop_front(); total_cnt++;
        if (bus.spi_rdata !== exp) $display("FAIL db_w1c: got %h want %h", bus.spi_rdata, exp); else pass_cnt++;
        total_cnt++;
        if (bus.upd_pulse !== 1'b0) $display("FAIL status_no_upd: got %0b want 0", bus.upd_pulse); else pass_cnt++;
    endtask

    task automatic test_coincident();
        logic [31:0] exp;
        exp_q.push_back(32'h00000201);
        spi_write(7'd127, 32'h00000077);
        bus.spi_addr = 7'd126; #1;
        exp = exp_q.pop_front(); total_cnt++;
        if (bus.spi_rdata !== exp) $display("FAIL coin_setup: got %h want %h", bus.spi_rdata, exp); else pass_cnt++;
        bus.cmd_ready = 1'b1;
        exp_q.push_back(32'h00000088);
        exp_q.push_back(32'h00000301);
        spi_write(7'd127, 32'h00000088);
        bus.cmd_ready = 1'b0;
        bus.spi_addr = 7'd126; #1;
        exp = exp_q.pop_front(); total_cnt++;
        if (bus.cmd_valid !== 1'b1 || bus.cmd_data !== exp)
            $display("FAIL coin_data: got valid=%0b data=%h want valid=1 data=%h", bus.cmd_valid, bus.cmd_data, exp);
        else pass_cnt++;
        exp = exp_q.pop_front(); total_cnt++;
        if (bus.spi_rdata !== exp) $display("FAIL coin_status: got %h want %h", bus.spi_rdata, exp); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp;
        bus.cmd_ready = 1'b1;
        reset = 1'b1;
        $display("[%0t] reset during pending command", $time);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        tick();
        reset = 1'b0; bus.cmd_ready = 1'b0;
        bus.spi_addr = 7'd126; #1;
        exp = exp_q.pop_front(); total_cnt++;
        if (bus.spi_rdata !== exp || bus.cmd_valid !== 1'b0)
            $display("FAIL rstmid_status: got status=%h valid=%0b want status=%h valid=0", bus.spi_rdata, bus.cmd_valid, exp);
        else pass_cnt++;
        bus.spi_addr = 7'd5; #1;
        exp = exp_q.pop_front(); total_cnt++;
        if (bus.spi_rdata !== exp) $display("FAIL rstmid_ram: got %h want %h", bus.spi_rdata, exp); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        bus.cmd_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            bus.spi_we = 1'b1; bus.spi_addr = 7'd127; bus.spi_wdata = 32'(i);
            tick();
        end
        bus.spi_we = 1'b0;
        $display("[%0t] 256 back-to-back doorbells issued", $time);
        exp_q.push_back(32'h000000FF);
        exp_q.push_back(32'h00000001);
        bus.spi_addr = 7'd126; #1;
        exp = exp_q.pop_front(); total_cnt++;
        if (bus.cmd_valid !== 1'b1 || bus.cmd_data !== exp)
            $display("FAIL b2b_data: got valid=%0b data=%h want valid=1 data=%h", bus.cmd_valid, bus.cmd_data, exp);
        else pass_cnt++;
        exp = exp_q.pop_front(); total_cnt++;
        if (bus.spi_rdata !== exp) $display("FAIL b2b_count_wrap: got %h want %h", bus.spi_rdata, exp); else pass_cnt++;
        bus.cmd_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_spi_write();
        test_cpu_port();
        test_collision();
        test_doorbell();
        test_coincident();
        test_reset_mid();
        test_back_to_back();
        tick();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/spi_regbank.md
Name: spi_regbank

Overview:
Shared register bank that sits directly downstream of the SPI slave. It consumes the SPI slave's write strobe, address and write data, and returns read data to it. It also exposes a second port to the on-chip processor side. Address 127 is a doorbell/command mailbox with a valid/ready handshake toward the processor. Address 126 is a status word readable over SPI.

Parameters:
ADDR_W, 7, address width (128 words)
DATA_W, 32, word width
STATUS_ADDR, 126, status word address
DOORBELL_ADDR, 127, command mailbox address

Ports:
Clk  input  1  system clock, all logic on posedge
Reset  input  1  synchronous, active-high reset
SPI_WE  input  1  write strobe from SPI slave, single-cycle pulse
SPI_Addr  input  7  SPI-side word address
SPI_WData  input  32  SPI-side write data
SPI_RData  output  32  SPI-side read data, combinational from SPI_Addr
CPU_WE  input  1  processor-side write enable
CPU_Addr  input  7  processor-side word address
CPU_WData  input  32  processor-side write data
CPU_RData  output  32  processor-side read data, registered, 1-cycle latency
Cmd_Valid  output  1  mailbox holds an unconsumed command
Cmd_Ready  input  1  processor accepts command
Cmd_Data  output  32  command word, stable while Cmd_Valid=1
Upd_Pulse  output  1  one-cycle pulse: SPI wrote a general word
Upd_Addr  output  7  address of that SPI write, valid with Upd_Pulse

Behaviour:
- Reset (synchronous, active-high):
  - All 126 general words are cleared to 0.
  - Cmd_Valid, Cmd_Data, overflow flag, doorbell count, CPU_RData, Upd_Pulse and Upd_Addr go to 0.
  - Reset mid-handshake discards any pending command; no accept is counted.
- Address map:
  - 0..125: general RAM.
  - 126: status. Bit0 = Cmd_Valid; bit1 = overflow (sticky); bits[15:8] = accepted-doorbell count, mod 256; all other bits 0.
  - 127: doorbell. Reads return the last accepted doorbell write (Cmd_Data register).
- SPI read:
  - SPI_RData is a pure combinational decode of SPI_Addr.
  - In a cycle with a same-address write, it shows the pre-write contents. The new value appears after the posedge.
- SPI write (on posedge when SPI_WE=1):
  - Addr <126: the word is written. Next cycle, Upd_Pulse=1 and Upd_Addr=SPI_Addr for exactly one cycle.
  - Addr 126: write-1-to-clear. SPI_WData[1]=1 clears overflow; all other bits are ignored. No Upd_Pulse.
  - Addr 127, mailbox empty (Cmd_Valid=0) or draining this cycle (Cmd_Valid & Cmd_Ready): Cmd_Data<=SPI_WData and Cmd_Valid<=1 next cycle. The doorbell count increments. No overflow.
  - Addr 127, mailbox busy (Cmd_Valid=1, Cmd_Ready=0): the write is dropped, Cmd_Data is unchanged, and overflow<=1. The count does not increment.
- Mailbox handshake:
  - Cmd_Valid clears on the posedge where Cmd_Valid & Cmd_Ready, unless a doorbell write is accepted in the same cycle.
  - Cmd_Ready while Cmd_Valid=0 has no effect.
  - Cmd_Data never changes while Cmd_Valid=1 and Cmd_Ready=0.
- CPU port:
  - Write on posedge when CPU_WE=1 and CPU_Addr<126. Writes to 126/127 are ignored.
  - CPU_RData <= decode(CPU_Addr) every cycle, whether or not CPU_WE is set. Decode uses the same map as the SPI side. Ordering is read-before-write: a same-cycle write to the same address returns the old value.
- Collision: SPI and CPU write the same general address in the same cycle → SPI wins; the CPU write is lost. Upd_Pulse still fires.
- Doorbell count wraps 255→0 silently.

Test Plan:
- Reset, then SPI_RData for addr 5 and addr 126 = 0x00000000; CPU_RData = 0 one cycle after CPU_Addr=5.
- SPI write 0xDEADBEEF to addr 5 → SPI_RData(5)=0xDEADBEEF after the edge. Upd_Pulse=1 with Upd_Addr=5 for exactly 1 cycle. CPU read of addr 5 returns 0xDEADBEEF after 1 cycle.
- SPI and CPU both write addr 10 in the same cycle (0x11111111 SPI, 0x22222222 CPU) → addr 10 = 0x11111111.
- Doorbell handshake, with Cmd_Ready held 0:
  - SPI write 0xA5 to 127 → next cycle Cmd_Valid=1, Cmd_Data=0xA5, status=0x00000101.
  - Second write 0x5A → Cmd_Data stays 0xA5; status=0x00000103.
  - Cmd_Ready=1 for one cycle → Cmd_Valid=0; status=0x00000102.
  - SPI write 0x2 to 126 → status=0x00000100.
- Doorbell write coincident with Cmd_Valid & Cmd_Ready → Cmd_Valid stays 1, Cmd_Data = new word, count +1, no overflow.
- Assert Reset while Cmd_Valid=1 and the count is 3 → next cycle Cmd_Valid=0, status=0, general RAM reads 0.
